alu_out_skid_reg: RTL and testbench

- Parametrised output register stage between the ALU/seven-segment decode logic and the board outputs/next consumer.
- Captures result, C/N/V/Z flags and per-digit segment codes with a valid/ready handshake and a one-entry skid buffer, so upstream never loses data when downstream stalls.
- Adds sticky (accumulated) flags and an accepted-transaction counter for debug display.

---
 rtl/alu_out_pkg.sv | 20 ++
 rtl/alu_out_slot.sv | 40 ++++
 rtl/alu_out_skid_reg.sv | 129 ++++++++++++
 tb/tb_alu_out_skid_reg.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_out_pkg.sv
// Shared types and constants for the ALU output register stage.
// Flag bit positions, state encoding and the blank segment code live here.
package alu_out_pkg;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef logic [3:0] flags_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/alu_out_slot.sv
// One storage slot of the skid stage: load-enabled register for result, flags and segments.
// Used both as the visible output register and as the hidden skid register.
module alu_out_slot
  import alu_out_pkg::*;
#(
  parameter int N      = 4,
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [N-1:0]          dResult,
  input  flags_t                dFlags,
  input  logic [7*DIGITS-1:0]   dSeg,
  output logic [N-1:0]          qResult,
  output flags_t                qFlags,
  output logic [7*DIGITS-1:0]   qSeg
);

  logic [N-1:0]        resultReg;
  flags_t              flagsReg;
  logic [7*DIGITS-1:0] segReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      resultReg <= '0;
      flagsReg  <= '0;
      segReg    <= {DIGITS{SEG_BLANK}};
    end else if (load) begin
      resultReg <= dResult;
      flagsReg  <= dFlags;
      segReg    <= dSeg;
    end
  end

  assign qResult = resultReg;
  assign qFlags  = flagsReg;
  assign qSeg    = segReg;

endmodule

// File: rtl/alu_out_skid_reg.sv
// Registered valid/ready output stage with a one-entry skid buffer, sticky flags
// and an accepted-word counter for debug display.
module alu_out_skid_reg
  import alu_out_pkg::*;
#(
  parameter int N      = 4,
  parameter int DIGITS = 1,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_result,
  input  logic [3:0]            in_flags,
  input  logic [7*DIGITS-1:0]   in_seg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_result,
  output logic [3:0]            out_flags,
  output logic [7*DIGITS-1:0]   out_seg,
  input  logic                  sticky_clr,
  output logic [3:0]            sticky_flags,
  output logic [CNT_W-1:0]      acc_cnt
);

  state_t stateReg, stateNext;
  logic   accept, drain;
  logic   loadO, loadS, oFromS;

  logic [N-1:0]        sResult, oResultD;
  flags_t              sFlags, oFlagsD;
  logic [7*DIGITS-1:0] sSeg, oSegD;

  flags_t            stickyReg;
  logic [CNT_W-1:0]  accCntReg;

  // Handshake depends only on registered state, so out_ready never reaches in_ready.
  assign in_ready  = (stateReg != FULL);
  assign out_valid = (stateReg != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) stateReg <= EMPTY;
    else     stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    loadO     = 1'b0;
    loadS     = 1'b0;
    oFromS    = 1'b0;
    case (stateReg)
      EMPTY: begin
        if (accept) begin
          loadO     = 1'b1;
          stateNext = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          loadO = 1'b1;
        end else if (accept) begin
          loadS     = 1'b1;
          stateNext = FULL;
        end else if (drain) begin
          stateNext = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          loadO     = 1'b1;
          oFromS    = 1'b1;
          stateNext = ONE;
        end
      end
      default: stateNext = EMPTY;
    endcase
  end

  // The output register refills from the skid entry first so ordering is kept.
  assign oResultD = oFromS ? sResult : in_result;
  assign oFlagsD  = oFromS ? sFlags  : in_flags;
  assign oSegD    = oFromS ? sSeg    : in_seg;

  alu_out_slot #(.N(N), .DIGITS(DIGITS)) oSlot (
    .clk     (clk),
    .rst     (rst),
    .load    (loadO),
    .dResult (oResultD),
    .dFlags  (oFlagsD),
    .dSeg    (oSegD),
    .qResult (out_result),
    .qFlags  (out_flags),
    .qSeg    (out_seg)
  );

  alu_out_slot #(.N(N), .DIGITS(DIGITS)) sSlot (
    .clk     (clk),
    .rst     (rst),
    .load    (loadS),
    .dResult (in_result),
    .dFlags  (in_flags),
    .dSeg    (in_seg),
    .qResult (sResult),
    .qFlags  (sFlags),
    .qSeg    (sSeg)
  );

  // A clear coinciding with an accept wipes history but still records the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      stickyReg <= '0;
      accCntReg <= '0;
    end else begin
      if (accept) begin
        stickyReg <= (sticky_clr ? 4'b0000 : stickyReg) | in_flags;
        accCntReg <= accCntReg + CNT_W'(1);
      end else if (sticky_clr) begin
        stickyReg <= '0;
      end
    end
  end

  assign sticky_flags = stickyReg;
  assign acc_cnt      = accCntReg;

endmodule

// File: tb/tb_alu_out_skid_reg.sv
// Self-checking bench for alu_out_skid_reg: directed steps plus random traffic
// checked against a two-deep FIFO reference model.
module tb_alu_out_skid_reg;

  localparam int N      = 4;
  localparam int DIGITS = 2;
  localparam int CNT_W  = 3;
  localparam int SW     = 7 * DIGITS;
  localparam int WW     = N + 4 + SW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N-1:0]      in_result = '0;
  logic [3:0]        in_flags = '0;
  logic [SW-1:0]     in_seg = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N-1:0]      out_result;
  logic [3:0]        out_flags;
  logic [SW-1:0]     out_seg;
  logic              sticky_clr = 1'b0;
  logic [3:0]        sticky_flags;
  logic [CNT_W-1:0]  acc_cnt;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: held words in arrival order, plus sticky/count bookkeeping.
  logic [WW-1:0] mq[$];
  logic [WW-1:0] mHeld = '0;
  logic [3:0]    mSticky = '0;
  int            mCnt = 0;

  always #5 clk = ~clk;

  alu_out_skid_reg #(.N(N), .DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_seg       (in_seg),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_seg      (out_seg),
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags),
    .acc_cnt      (acc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic cycle(input logic r, input logic v, input logic [N-1:0] res,
                       input logic [3:0] fl, input logic ordy, input logic clr,
                       input bit doCheck, output bit accepted);
    logic [WW-1:0] shown;
    logic [WW-1:0] word;
    logic [SW-1:0] sg;
    bit acc, drn;
    sg = SW'($urandom);
    @(negedge clk);
    rst = r; in_valid = v; in_result = res; in_flags = fl; in_seg = sg;
    out_ready = ordy; sticky_clr = clr;
    #1;
    shown = (mq.size() > 0) ? mq[0] : mHeld;
    if (doCheck) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      chk("out_result", 32'(out_result), 32'(shown[WW-1 -: N]));
      chk("out_flags", 32'(out_flags), 32'(shown[SW+3 -: 4]));
      chk("out_seg", 32'(out_seg), 32'(shown[SW-1:0]));
      chk("sticky_flags", 32'(sticky_flags), 32'(mSticky));
      chk("acc_cnt", 32'(acc_cnt), 32'(mCnt));
    end
    word = {res, fl, sg};
    acc = !r && v && (mq.size() < 2);
    drn = !r && (mq.size() > 0) && ordy;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mHeld = '0;
      mSticky = '0;
      mCnt = 0;
    end else begin
      if (drn) mHeld = mq.pop_front();
      if (acc) begin
        mq.push_back(word);
        mSticky = (clr ? 4'b0000 : mSticky) | fl;
        mCnt = (mCnt + 1) % (1 << CNT_W);
      end else if (clr) begin
        mSticky = '0;
      end
    end
    accepted = acc;
    $display("[TB] t=%0t rst=%0b v=%0b res=%0h fl=%0h ordy=%0b clr=%0b acc=%0b drn=%0b",
             $time, r, v, res, fl, ordy, clr, acc, drn);
  endtask

  task automatic send(input logic [N-1:0] res, input logic [3:0] fl, input logic ordy);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) cycle(1'b0, 1'b1, res, fl, ordy, 1'b0, 1'b1, a);
    if (!a) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, ordy, 1'b0, 1'b1, a);
  endtask

  task automatic doReset(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, a);
  endtask

  initial begin
    bit a;
    // Reset with in_valid held high; first cycle precedes any defined state.
    cycle(1'b1, 1'b1, 4'hA, 4'hF, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b1, 4'hA, 4'hF, 1'b0, 1'b0, 1'b1, a);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);

    // Streaming at full throughput.
    send(4'd3, 4'b0000, 1'b1);
    send(4'd7, 4'b0000, 1'b1);
    send(4'd9, 4'b0000, 1'b1);
    #1;
    chk("stream_result", 32'(out_result), 32'd9);
    chk("stream_cnt", 32'(acc_cnt), 32'd3);
    idle(2, 1'b1);

    // Stall: fill O and S, third word is held off.
    send(4'd5, 4'b0010, 1'b0);
    send(4'd6, 4'b0100, 1'b0);
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_result", 32'(out_result), 32'd5);
    cycle(1'b0, 1'b1, 4'd8, 4'b0001, 1'b0, 1'b0, 1'b1, a);
    chk("stall_held_off", 32'(a), 32'd0);
    send(4'd8, 4'b0001, 1'b1);
    #1;
    chk("stall_last", 32'(out_result), 32'd8);
    idle(3, 1'b1);

    // Sticky accumulation and clear.
    doReset(1);
    send(4'd1, 4'b1000, 1'b1);
    send(4'd2, 4'b0001, 1'b1);
    #1;
    chk("sticky_or", 32'(sticky_flags), 32'h9);
    cycle(1'b0, 1'b1, 4'd3, 4'b0100, 1'b1, 1'b1, 1'b1, a);
    #1;
    chk("sticky_clr_acc", 32'(sticky_flags), 32'h4);
    cycle(1'b0, 1'b0, 4'd0, 4'b1111, 1'b1, 1'b1, 1'b1, a);
    #1;
    chk("sticky_clr_only", 32'(sticky_flags), 32'h0);
    idle(2, 1'b1);

    // Counter wrap with a 3-bit counter.
    doReset(1);
    for (int i = 0; i < 9; i++) send(N'(i), 4'b0000, 1'b1);
    #1;
    chk("wrap_cnt", 32'(acc_cnt), 32'd1);
    idle(2, 1'b1);

    // Reset while FULL discards both entries.
    send(4'd11, 4'b0000, 1'b0);
    send(4'd12, 4'b0000, 1'b0);
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_result", 32'(out_result), 32'd0);
    chk("midrst_cnt", 32'(acc_cnt), 32'd0);
    send(4'd13, 4'b0000, 1'b1);
    idle(1, 1'b1);
    #1;
    chk("alone_empty", 32'(out_valid), 32'd0);
    chk("alone_result", 32'(out_result), 32'd13);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 63) == 0), 1'($urandom), N'($urandom), 4'($urandom),
            1'($urandom), ($urandom_range(0, 7) == 0), 1'b1, a);
    end
    idle(3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
